// File: rtl/stopwatch_lap_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_lap_ctrl_if
//  Description : Lap readout port (valid/ready stream of captured lap times).
//                master = lap producer (controller), slave = lap consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface stopwatch_lap_ctrl_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  lap_valid;
  logic                  lap_ready;
  logic [DATA_WIDTH-1:0] lap_data;

  modport master (
    output lap_valid,
    output lap_data,
    input  lap_ready
  );

  modport slave (
    input  lap_valid,
    input  lap_data,
    output lap_ready
  );
endinterface
`default_nettype wire

// File: rtl/stopwatch_lap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_lap_ctrl
//  Description : Control FSM for a free-running stopwatch. Converts the two
//                user command pulses into single-cycle start/stop/reset
//                pulses, captures lap times into a small FIFO drained over a
//                valid/ready port, and counts MAX->0 wraps while running.
//  Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_lap_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX        = 99,
  parameter int LAP_DEPTH  = 4
) (
  input  wire logic                            clk,
  input  wire logic                            reset,
  input  wire logic                            cmd_startstop_i,
  input  wire logic                            cmd_lapclr_i,
  input  wire logic [DATA_WIDTH-1:0]           sw_count_i,
  output logic                                 sw_start_o,
  output logic                                 sw_stop_o,
  output logic                                 sw_reset_o,
  output logic [1:0]                           state_o,
  output logic [$clog2(LAP_DEPTH):0]           lap_level_o,
  output logic                                 lap_overflow_o,
  output logic [7:0]                           wrap_cnt_o,
  stopwatch_lap_ctrl_if.master                 lap_if
);

  localparam int ADDR_W  = $clog2(LAP_DEPTH);
  localparam int LEVEL_W = ADDR_W + 1;
  localparam logic [LEVEL_W-1:0]    FULL_LEVEL = LEVEL_W'(LAP_DEPTH);
  localparam logic [LEVEL_W-1:0]    LEVEL_ONE  = LEVEL_W'(1);
  localparam logic [ADDR_W-1:0]     PTR_ONE    = ADDR_W'(1);
  localparam logic [DATA_WIDTH-1:0] MAX_COUNT  = DATA_WIDTH'(MAX);
  localparam logic [7:0]            WRAP_SAT   = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   sw_start_q, sw_start_d;
  logic   sw_stop_q,  sw_stop_d;
  logic   sw_reset_q, sw_reset_d;
  logic   push_req;
  logic   clear_req;

  logic [DATA_WIDTH-1:0] mem_q [LAP_DEPTH];
  logic [ADDR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LEVEL_W-1:0]    level_q;
  logic                  overflow_q;
  logic                  fifo_full;
  logic                  fifo_pop;
  logic                  push_ok;
  logic                  push_drop;

  logic [DATA_WIDTH-1:0] prev_count_q;
  logic [7:0]            wrap_cnt_q;

  // State register and registered stopwatch pulses; sw_reset is held high in
  // reset so the stopwatch is cleared on the first edge after release.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sw_start_q <= 1'b0;
      sw_stop_q  <= 1'b0;
      sw_reset_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      sw_start_q <= sw_start_d;
      sw_stop_q  <= sw_stop_d;
      sw_reset_q <= sw_reset_d;
    end
  end

  // Command decode: next state, next pulses, lap push and clear requests.
  // In RUN a lap is pushed even when a stop arrives in the same cycle; in
  // PAUSE a resume takes priority over a clear.
  always_comb begin
    state_d    = state_q;
    sw_start_d = 1'b0;
    sw_stop_d  = 1'b0;
    sw_reset_d = 1'b0;
    push_req   = 1'b0;
    clear_req  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_startstop_i) begin
          state_d    = ST_RUN;
          sw_start_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (cmd_lapclr_i) begin
          push_req = 1'b1;
        end
        if (cmd_startstop_i) begin
          state_d   = ST_PAUSE;
          sw_stop_d = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (cmd_startstop_i) begin
          state_d    = ST_RUN;
          sw_start_d = 1'b1;
        end else if (cmd_lapclr_i) begin
          state_d    = ST_IDLE;
          sw_reset_d = 1'b1;
          clear_req  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A full FIFO still accepts a lap when the head is popped in the same cycle.
  assign fifo_full = (level_q == FULL_LEVEL);
  assign fifo_pop  = (level_q != '0) && lap_if.lap_ready;
  assign push_ok   = push_req && (!fifo_full || fifo_pop);
  assign push_drop = push_req && fifo_full && !fifo_pop;

  // FIFO pointers, occupancy and sticky overflow; clear flushes unconditionally.
  always_ff @(posedge clk) begin
    if (reset || clear_req) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (fifo_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      case ({push_ok, fifo_pop})
        2'b10:   level_q <= level_q + LEVEL_ONE;
        2'b01:   level_q <= level_q - LEVEL_ONE;
        default: level_q <= level_q;
      endcase
      if (push_drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Lap storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= sw_count_i;
    end
  end

  // Wrap counter: a MAX->0 step of the observed count while in RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_count_q <= '0;
      wrap_cnt_q   <= '0;
    end else begin
      prev_count_q <= sw_count_i;
      if (clear_req) begin
        wrap_cnt_q <= '0;
      end else if (state_q == ST_RUN && prev_count_q == MAX_COUNT &&
                   sw_count_i == '0 && wrap_cnt_q != WRAP_SAT) begin
        wrap_cnt_q <= wrap_cnt_q + 8'd1;
      end
    end
  end

  assign sw_start_o       = sw_start_q;
  assign sw_stop_o        = sw_stop_q;
  assign sw_reset_o       = sw_reset_q;
  assign state_o          = state_q;
  assign lap_level_o      = level_q;
  assign lap_overflow_o   = overflow_q;
  assign wrap_cnt_o       = wrap_cnt_q;
  assign lap_if.lap_valid = (level_q != '0);
  assign lap_if.lap_data  = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_lap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stopwatch_lap_ctrl
//  Description : Directed, table-driven bench for stopwatch_lap_ctrl with
//                hand-written sequences for saturation and mid-run reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_lap_ctrl;

  localparam int DW = 16;
  localparam int NV = 35;

  logic          clk;
  logic          reset;
  logic          cmd_startstop;
  logic          cmd_lapclr;
  logic [DW-1:0] sw_count;
  logic          sw_start, sw_stop, sw_reset;
  logic [1:0]    state;
  logic [2:0]    lap_level;
  logic          lap_overflow;
  logic [7:0]    wrap_cnt;

  int checks;
  int errors;

  stopwatch_lap_ctrl_if #(.DATA_WIDTH(DW)) lap_if ();

  stopwatch_lap_ctrl #(
    .DATA_WIDTH(DW),
    .MAX       (99),
    .LAP_DEPTH (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_startstop_i(cmd_startstop),
    .cmd_lapclr_i   (cmd_lapclr),
    .sw_count_i     (sw_count),
    .sw_start_o     (sw_start),
    .sw_stop_o      (sw_stop),
    .sw_reset_o     (sw_reset),
    .state_o        (state),
    .lap_level_o    (lap_level),
    .lap_overflow_o (lap_overflow),
    .wrap_cnt_o     (wrap_cnt),
    .lap_if         (lap_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          ss, lc, rdy;
    logic [DW-1:0] cnt;
    logic [1:0]    e_st;
    logic          e_sa, e_so, e_sr, e_val;
    logic [DW-1:0] e_data;
    logic [2:0]    e_lvl;
    logic          e_ovf;
    logic [7:0]    e_wrap;
  } vec_t;

  vec_t tbl [NV];

  function automatic vec_t mk(input logic ss, lc, rdy, input int cnt,
                              input int st, input logic sa, so, sr, val,
                              input int data, input int lvl, input logic ovf,
                              input int wrap);
    vec_t v;
    v.ss = ss; v.lc = lc; v.rdy = rdy; v.cnt = DW'(cnt);
    v.e_st = 2'(st); v.e_sa = sa; v.e_so = so; v.e_sr = sr; v.e_val = val;
    v.e_data = DW'(data); v.e_lvl = 3'(lvl); v.e_ovf = ovf; v.e_wrap = 8'(wrap);
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1; cmd_startstop = 1'b0; cmd_lapclr = 1'b0;
    sw_count = '0; lap_if.lap_ready = 1'b0;

    //            ss lc rd cnt  st sa so sr va data lv ov wrap
    tbl[0]  = mk(0, 1, 0, 0,   0, 0, 0, 0, 0, 0,  0, 0, 0);  // lapclr ignored in IDLE
    tbl[1]  = mk(1, 0, 0, 0,   1, 1, 0, 0, 0, 0,  0, 0, 0);  // start
    tbl[2]  = mk(0, 0, 0, 1,   1, 0, 0, 0, 0, 0,  0, 0, 0);
    tbl[3]  = mk(0, 1, 0, 7,   1, 0, 0, 0, 1, 7,  1, 0, 0);  // lap 7
    tbl[4]  = mk(0, 0, 0, 8,   1, 0, 0, 0, 1, 7,  1, 0, 0);
    tbl[5]  = mk(0, 1, 0, 12,  1, 0, 0, 0, 1, 7,  2, 0, 0);  // lap 12
    tbl[6]  = mk(0, 0, 1, 13,  1, 0, 0, 0, 1, 12, 1, 0, 0);  // pop 7
    tbl[7]  = mk(0, 0, 1, 14,  1, 0, 0, 0, 0, 0,  0, 0, 0);  // pop 12
    tbl[8]  = mk(0, 0, 1, 15,  1, 0, 0, 0, 0, 0,  0, 0, 0);  // pop on empty
    tbl[9]  = mk(0, 1, 0, 20,  1, 0, 0, 0, 1, 20, 1, 0, 0);
    tbl[10] = mk(0, 1, 0, 21,  1, 0, 0, 0, 1, 20, 2, 0, 0);
    tbl[11] = mk(0, 1, 0, 22,  1, 0, 0, 0, 1, 20, 3, 0, 0);
    tbl[12] = mk(0, 1, 0, 23,  1, 0, 0, 0, 1, 20, 4, 0, 0);
    tbl[13] = mk(0, 1, 0, 24,  1, 0, 0, 0, 1, 20, 4, 1, 0);  // dropped
    tbl[14] = mk(0, 1, 1, 25,  1, 0, 0, 0, 1, 21, 4, 1, 0);  // full push+pop
    tbl[15] = mk(0, 0, 1, 26,  1, 0, 0, 0, 1, 22, 3, 1, 0);
    tbl[16] = mk(0, 0, 1, 27,  1, 0, 0, 0, 1, 23, 2, 1, 0);
    tbl[17] = mk(0, 0, 1, 28,  1, 0, 0, 0, 1, 25, 1, 1, 0);
    tbl[18] = mk(0, 0, 1, 29,  1, 0, 0, 0, 0, 0,  0, 1, 0);
    tbl[19] = mk(0, 1, 0, 30,  1, 0, 0, 0, 1, 30, 1, 1, 0);
    tbl[20] = mk(0, 1, 1, 31,  1, 0, 0, 0, 1, 31, 1, 1, 0);  // push+pop not full
    tbl[21] = mk(0, 0, 0, 98,  1, 0, 0, 0, 1, 31, 1, 1, 0);
    tbl[22] = mk(0, 0, 0, 99,  1, 0, 0, 0, 1, 31, 1, 1, 0);
    tbl[23] = mk(0, 0, 0, 0,   1, 0, 0, 0, 1, 31, 1, 1, 1);  // wrap 1
    tbl[24] = mk(0, 0, 0, 1,   1, 0, 0, 0, 1, 31, 1, 1, 1);
    tbl[25] = mk(0, 0, 0, 99,  1, 0, 0, 0, 1, 31, 1, 1, 1);
    tbl[26] = mk(0, 0, 0, 0,   1, 0, 0, 0, 1, 31, 1, 1, 2);  // wrap 2
    tbl[27] = mk(0, 0, 0, 0,   1, 0, 0, 0, 1, 31, 1, 1, 2);
    tbl[28] = mk(1, 1, 0, 40,  2, 0, 1, 0, 1, 31, 2, 1, 2);  // lap 40 + stop
    tbl[29] = mk(0, 0, 0, 99,  2, 0, 0, 0, 1, 31, 2, 1, 2);
    tbl[30] = mk(0, 0, 0, 0,   2, 0, 0, 0, 1, 31, 2, 1, 2);  // no wrap in PAUSE
    tbl[31] = mk(1, 1, 0, 0,   1, 1, 0, 0, 1, 31, 2, 1, 2);  // resume wins
    tbl[32] = mk(1, 0, 0, 41,  2, 0, 1, 0, 1, 31, 2, 1, 2);
    tbl[33] = mk(0, 1, 0, 41,  0, 0, 0, 1, 0, 0,  0, 0, 0);  // clear
    tbl[34] = mk(0, 0, 0, 0,   0, 0, 0, 0, 0, 0,  0, 0, 0);

    // Reset state
    repeat (3) tick();
    chk("rst_state",    -1, 32'(state),          32'd0);
    chk("rst_sw_reset", -1, 32'(sw_reset),       32'd1);
    chk("rst_sw_start", -1, 32'(sw_start),       32'd0);
    chk("rst_sw_stop",  -1, 32'(sw_stop),        32'd0);
    chk("rst_valid",    -1, 32'(lap_if.lap_valid), 32'd0);
    chk("rst_level",    -1, 32'(lap_level),      32'd0);
    chk("rst_ovf",      -1, 32'(lap_overflow),   32'd0);
    chk("rst_wrap",     -1, 32'(wrap_cnt),       32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_sw_reset", -1, 32'(sw_reset), 32'd0);

    for (int i = 0; i < NV; i++) begin
      cmd_startstop    = tbl[i].ss;
      cmd_lapclr       = tbl[i].lc;
      lap_if.lap_ready = tbl[i].rdy;
      sw_count         = tbl[i].cnt;
      tick();
      chk("state",    i, 32'(state),             32'(tbl[i].e_st));
      chk("sw_start", i, 32'(sw_start),          32'(tbl[i].e_sa));
      chk("sw_stop",  i, 32'(sw_stop),           32'(tbl[i].e_so));
      chk("sw_reset", i, 32'(sw_reset),          32'(tbl[i].e_sr));
      chk("valid",    i, 32'(lap_if.lap_valid),  32'(tbl[i].e_val));
      chk("level",    i, 32'(lap_level),         32'(tbl[i].e_lvl));
      chk("overflow", i, 32'(lap_overflow),      32'(tbl[i].e_ovf));
      chk("wrap",     i, 32'(wrap_cnt),          32'(tbl[i].e_wrap));
      if (tbl[i].e_val) begin
        chk("data",   i, 32'(lap_if.lap_data),   32'(tbl[i].e_data));
      end
    end
    cmd_startstop = 1'b0; cmd_lapclr = 1'b0; lap_if.lap_ready = 1'b0;

    // Wrap counter saturation
    cmd_startstop = 1'b1; sw_count = '0;
    tick();
    cmd_startstop = 1'b0;
    chk("sat_run", 100, 32'(state), 32'd1);
    for (int k = 0; k < 260; k++) begin
      sw_count = 16'd99; tick();
      sw_count = 16'd0;  tick();
    end
    chk("sat_wrap", 101, 32'(wrap_cnt), 32'd255);

    // Reset mid-run with three laps queued
    for (int k = 1; k <= 3; k++) begin
      cmd_lapclr = 1'b1; sw_count = DW'(k * 5);
      tick();
    end
    cmd_lapclr = 1'b0;
    chk("q3_level", 102, 32'(lap_level),        32'd3);
    chk("q3_data",  102, 32'(lap_if.lap_data),  32'd5);
    reset = 1'b1;
    tick();
    chk("mid_rst_state",    103, 32'(state),            32'd0);
    chk("mid_rst_valid",    103, 32'(lap_if.lap_valid), 32'd0);
    chk("mid_rst_level",    103, 32'(lap_level),        32'd0);
    chk("mid_rst_sw_reset", 103, 32'(sw_reset),         32'd1);
    chk("mid_rst_wrap",     103, 32'(wrap_cnt),         32'd0);
    reset = 1'b0;
    tick();
    chk("after_rst_sw_reset", 104, 32'(sw_reset), 32'd0);
    chk("after_rst_state",    104, 32'(state),    32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
